mem_line_transfer: RTL and testbench

Bus-side line transfer engine between the L1 cache and the memory bus. It takes whole-line fill and writeback requests from the cache, sequences the bus request/acknowledge handshake, and streams the 8 × 64-bit beats of a 64-byte line out (writeback) or in (fill). A completed fill is presented to the cache as one 512-bit line with a single-cycle valid pulse.

---
 rtl/mem_line_transfer_pkg.sv | 23 ++
 rtl/mem_line_transfer_beat_assembler.sv | 57 +++++
 rtl/mem_line_transfer.sv | 248 ++++++++++++++++++++++++
 tb/tb_mem_line_transfer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_line_transfer_pkg.sv
// Shared types and constants for the bus-side line transfer engine.
package mem_line_transfer_pkg;

  localparam int BEATS          = 8;
  localparam int OFFSET_W       = 6;
  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;

  localparam logic [BUS_TAG_WIDTH-1:0] MEM_READ  = 13'h0001;
  localparam logic [BUS_TAG_WIDTH-1:0] MEM_WRITE = 13'h0002;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } ltu_state_t;

  typedef logic [BEATS-1:0][BUS_DATA_WIDTH-1:0] cache_line_t;

endpackage

// File: rtl/mem_line_transfer_beat_assembler.sv
// Beat counter plus slot register: serves writeback beats out and collects fill beats in.
module beat_assembler
  import mem_line_transfer_pkg::*;
#(
  parameter int BEATS = mem_line_transfer_pkg::BEATS,
  parameter int W     = BUS_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic [BEATS*W-1:0]         i_line,
  input  logic                       i_clear,
  input  logic                       i_adv,
  input  logic                       i_capture,
  input  logic [W-1:0]               i_beat,
  output logic [$clog2(BEATS)-1:0]   o_cnt,
  output logic [W-1:0]               o_beat,
  output logic                       o_last,
  output logic [BEATS*W-1:0]         o_line_nxt
);

  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]          r_cnt;
  logic [BEATS-1:0][W-1:0]   r_slots;
  logic [BEATS-1:0][W-1:0]   w_slots_cap;

  // Slot image with the incoming beat already placed; becomes the line on the last capture.
  always_comb begin
    w_slots_cap        = r_slots;
    w_slots_cap[r_cnt] = i_beat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_slots <= '0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_slots <= i_line;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_slots <= '0;
    end else if (i_capture) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_slots <= w_slots_cap;
    end else if (i_adv) begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_beat     = r_slots[r_cnt];
  assign o_last     = (r_cnt == CNT_W'(BEATS - 1));
  assign o_line_nxt = w_slots_cap;

endmodule

// File: rtl/mem_line_transfer.sv
// Line fill / writeback engine between the L1 cache and the memory bus; all outputs registered.
// Define LTU_EVICT_FILL_EN to accept a fill together with a writeback and run it right after.
module mem_line_transfer
  import mem_line_transfer_pkg::*;
#(
  parameter int BEATS    = mem_line_transfer_pkg::BEATS,
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = mem_line_transfer_pkg::OFFSET_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fill_req,
  input  logic [ADDR_W-1:0]         fill_addr,
  input  logic                      wb_req,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [BEATS*64-1:0]       wb_line,
  output logic                      req_ready,
  output logic                      line_valid,
  output logic [BEATS*64-1:0]       line_data,
  output logic                      wb_done,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  // state   | meaning
  // IDLE    | ready for a request
  // WR_ADDR | writeback address on the bus, waiting for reqack
  // WR_DATA | streaming writeback beats 0..BEATS-1
  // WR_RESP | waiting for the write response
  // RD_ADDR | fill address on the bus, waiting for reqack
  // RD_DATA | collecting fill beats

  localparam int CNT_W = $clog2(BEATS);

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m                 = a;
    m[OFFSET_W-1:0]   = '0;
    return m;
  endfunction

  ltu_state_t                r_state, w_state_nxt;
  logic [ADDR_W-1:0]         r_addr, w_addr_nxt;

  logic                      r_req_ready;
  logic                      r_line_valid, w_line_valid_nxt;
  logic [BEATS*64-1:0]       r_line_data;
  logic                      r_wb_done, w_wb_done_nxt;
  logic                      r_bus_reqcyc, w_reqcyc_nxt;
  logic [BUS_DATA_WIDTH-1:0] r_bus_req, w_req_nxt;
  logic [BUS_TAG_WIDTH-1:0]  r_bus_reqtag, w_tag_nxt;
  logic                      r_bus_respack, w_respack_nxt;

  logic                      w_asm_load, w_asm_clear, w_asm_adv, w_asm_cap;
  logic [CNT_W-1:0]          w_cnt;
  logic [63:0]               w_beat;
  logic                      w_last;
  logic [BEATS*64-1:0]       w_fill_line;

  logic                      w_resp_wr, w_resp_rd;

`ifdef LTU_EVICT_FILL_EN
  logic                      r_pend_vld, w_pend_vld_nxt;
  logic [ADDR_W-1:0]         r_pend_addr, w_pend_addr_nxt;
`endif

  assign w_resp_wr = bus_respcyc && (bus_resptag == MEM_WRITE);
  assign w_resp_rd = bus_respcyc && (bus_resptag == MEM_READ);

  beat_assembler #(
    .BEATS (BEATS),
    .W     (64)
  ) u_beat_assembler (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_asm_load),
    .i_line     (wb_line),
    .i_clear    (w_asm_clear),
    .i_adv      (w_asm_adv),
    .i_capture  (w_asm_cap),
    .i_beat     (bus_resp),
    .o_cnt      (w_cnt),
    .o_beat     (w_beat),
    .o_last     (w_last),
    .o_line_nxt (w_fill_line)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_reqcyc_nxt     = 1'b0;
    w_req_nxt        = '0;
    w_tag_nxt        = '0;
    w_respack_nxt    = 1'b0;
    w_wb_done_nxt    = 1'b0;
    w_line_valid_nxt = 1'b0;
    w_asm_load       = 1'b0;
    w_asm_clear      = 1'b0;
    w_asm_adv        = 1'b0;
    w_asm_cap        = 1'b0;
`ifdef LTU_EVICT_FILL_EN
    w_pend_vld_nxt   = r_pend_vld;
    w_pend_addr_nxt  = r_pend_addr;
`endif
    unique case (r_state)
      IDLE: begin
        if (wb_req) begin
          w_state_nxt  = WR_ADDR;
          w_addr_nxt   = align(wb_addr);
          w_reqcyc_nxt = 1'b1;
          w_req_nxt    = BUS_DATA_WIDTH'(align(wb_addr));
          w_tag_nxt    = MEM_WRITE;
          w_asm_load   = 1'b1;
`ifdef LTU_EVICT_FILL_EN
          if (fill_req) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = align(fill_addr);
          end
`endif
        end else if (fill_req) begin
          w_state_nxt  = RD_ADDR;
          w_addr_nxt   = align(fill_addr);
          w_reqcyc_nxt = 1'b1;
          w_req_nxt    = BUS_DATA_WIDTH'(align(fill_addr));
          w_tag_nxt    = MEM_READ;
          w_asm_clear  = 1'b1;
        end
      end
      WR_ADDR: begin
        w_reqcyc_nxt = 1'b1;
        w_tag_nxt    = MEM_WRITE;
        if (bus_reqack) begin
          w_state_nxt = WR_DATA;
          w_req_nxt   = w_beat;
          w_asm_adv   = 1'b1;
        end else begin
          w_req_nxt   = BUS_DATA_WIDTH'(r_addr);
        end
      end
      WR_DATA: begin
        // Counter points at the next beat to send; wrapping to 0 means the last beat is on the bus.
        if (w_cnt == '0) begin
          w_state_nxt  = WR_RESP;
        end else begin
          w_reqcyc_nxt = 1'b1;
          w_tag_nxt    = MEM_WRITE;
          w_req_nxt    = w_beat;
          w_asm_adv    = 1'b1;
        end
      end
      WR_RESP: begin
        if (w_resp_wr) begin
          w_respack_nxt = 1'b1;
          w_wb_done_nxt = 1'b1;
          w_state_nxt   = IDLE;
`ifdef LTU_EVICT_FILL_EN
          if (r_pend_vld) begin
            w_state_nxt    = RD_ADDR;
            w_addr_nxt     = r_pend_addr;
            w_reqcyc_nxt   = 1'b1;
            w_req_nxt      = BUS_DATA_WIDTH'(r_pend_addr);
            w_tag_nxt      = MEM_READ;
            w_asm_clear    = 1'b1;
            w_pend_vld_nxt = 1'b0;
          end
`endif
        end
      end
      RD_ADDR: begin
        if (bus_reqack) begin
          w_state_nxt  = RD_DATA;
        end else begin
          w_reqcyc_nxt = 1'b1;
          w_req_nxt    = BUS_DATA_WIDTH'(r_addr);
          w_tag_nxt    = MEM_READ;
        end
      end
      RD_DATA: begin
        if (w_resp_rd) begin
          w_asm_cap     = 1'b1;
          w_respack_nxt = 1'b1;
          if (w_last) begin
            w_state_nxt      = IDLE;
            w_line_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr        <= '0;
      r_req_ready   <= 1'b1;
      r_line_valid  <= 1'b0;
      r_line_data   <= '0;
      r_wb_done     <= 1'b0;
      r_bus_reqcyc  <= 1'b0;
      r_bus_req     <= '0;
      r_bus_reqtag  <= '0;
      r_bus_respack <= 1'b0;
    end else begin
      r_addr        <= w_addr_nxt;
      r_req_ready   <= (w_state_nxt == IDLE);
      r_line_valid  <= w_line_valid_nxt;
      r_wb_done     <= w_wb_done_nxt;
      r_bus_reqcyc  <= w_reqcyc_nxt;
      r_bus_req     <= w_req_nxt;
      r_bus_reqtag  <= w_tag_nxt;
      r_bus_respack <= w_respack_nxt;
      if (w_line_valid_nxt) r_line_data <= w_fill_line;
    end
  end

`ifdef LTU_EVICT_FILL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
    end else begin
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end
`endif

  assign req_ready   = r_req_ready;
  assign line_valid  = r_line_valid;
  assign line_data   = r_line_data;
  assign wb_done     = r_wb_done;
  assign bus_reqcyc  = r_bus_reqcyc;
  assign bus_req     = r_bus_req;
  assign bus_reqtag  = r_bus_reqtag;
  assign bus_respack = r_bus_respack;

endmodule

// File: tb/tb_mem_line_transfer.sv
// Self-checking bench for mem_line_transfer: directed cases plus randomized fills/writebacks.
module tb_mem_line_transfer;
  import mem_line_transfer_pkg::BUS_TAG_WIDTH;
  import mem_line_transfer_pkg::MEM_READ;
  import mem_line_transfer_pkg::MEM_WRITE;
  import mem_line_transfer_pkg::cache_line_t;

  localparam int NB = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     fill_req = 1'b0;
  logic [63:0]              fill_addr = '0;
  logic                     wb_req = 1'b0;
  logic [63:0]              wb_addr = '0;
  cache_line_t              wb_line = '0;
  logic                     req_ready;
  logic                     line_valid;
  logic [NB*64-1:0]         line_data;
  logic                     wb_done;
  logic                     bus_reqcyc;
  logic [63:0]              bus_req;
  logic [BUS_TAG_WIDTH-1:0] bus_reqtag;
  logic                     bus_reqack = 1'b0;
  logic                     bus_respcyc = 1'b0;
  logic [63:0]              bus_resp = '0;
  logic [BUS_TAG_WIDTH-1:0] bus_resptag = '0;
  logic                     bus_respack;

  int n_checks = 0;
  int n_errors = 0;
  int n_respack = 0;
  int n_line_valid = 0;
  int n_wb_done = 0;
  int n_fills = 0;
  int n_wbs = 0;

  mem_line_transfer dut (
    .clk         (clk),
    .reset       (reset),
    .fill_req    (fill_req),
    .fill_addr   (fill_addr),
    .wb_req      (wb_req),
    .wb_addr     (wb_addr),
    .wb_line     (wb_line),
    .req_ready   (req_ready),
    .line_valid  (line_valid),
    .line_data   (line_data),
    .wb_done     (wb_done),
    .bus_reqcyc  (bus_reqcyc),
    .bus_req     (bus_req),
    .bus_reqtag  (bus_reqtag),
    .bus_reqack  (bus_reqack),
    .bus_respcyc (bus_respcyc),
    .bus_resp    (bus_resp),
    .bus_resptag (bus_resptag),
    .bus_respack (bus_respack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_respack) n_respack++;
    if (line_valid)  n_line_valid++;
    if (wb_done)     n_wb_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill phase from the point the read address is visible on the bus.
  task automatic rd_phase(input logic [63:0] exp_a, input int ack_dly, input int stray_at, input bit seq);
    cache_line_t exp_line;
    logic [63:0] beat;
    int          rp0;
    bit          stable;
    exp_line = '0;
    check("rd_addr_cyc", bus_reqcyc, 1);
    check("rd_addr", bus_req, exp_a);
    check("rd_tag", bus_reqtag, MEM_READ);
    stable = 1'b1;
    repeat (ack_dly) begin
      step();
      if (!(bus_reqcyc && bus_req == exp_a && bus_reqtag == MEM_READ && !req_ready)) stable = 1'b0;
    end
    check("rd_addr_hold", stable, 1);
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    check("rd_cyc_drop", {bus_reqcyc, bus_req, bus_reqtag}, 0);
    rp0 = n_respack;
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 2) == 0) step();
      if (i == stray_at) begin
        bus_respcyc = 1'b1;
        bus_resptag = MEM_WRITE;
        bus_resp    = {$urandom, $urandom};
        step();
        bus_respcyc = 1'b0;
        check("stray_noack", {bus_respack, line_valid}, 0);
      end
      beat        = seq ? 64'(i) : {$urandom, $urandom};
      exp_line[i] = beat;
      bus_respcyc = 1'b1;
      bus_resptag = MEM_READ;
      bus_resp    = beat;
      step();
      bus_respcyc = 1'b0;
      check("rd_beat_ack", bus_respack, 1);
      check("rd_valid", line_valid, (i == NB - 1));
    end
    check("line_data", line_data, exp_line);
    check("rd_done_ready", req_ready, 1);
    n_fills++;
    step();
    check("valid_1cyc", {line_valid, bus_respack}, 0);
    check("respack_cnt", n_respack - rp0, NB);
  endtask

  task automatic fill_txn(input logic [63:0] addr, input int ack_dly, input int stray_at, input bit seq);
    fill_addr = addr;
    fill_req  = 1'b1;
    check("fill_ready", req_ready, 1);
    step();
    fill_req  = 1'b0;
    fill_addr = {$urandom, $urandom};
    check("fill_busy", req_ready, 0);
    rd_phase(addr & ~64'h3f, ack_dly, stray_at, seq);
  endtask

  task automatic wb_txn(input logic [63:0] addr, input cache_line_t line, input int ack_dly,
                        input bit both, input logic [63:0] faddr);
    logic [63:0] exp_a;
    bit          stable;
    bit          chain;
    exp_a   = addr & ~64'h3f;
    wb_addr = addr;
    wb_line = line;
    wb_req  = 1'b1;
    if (both) begin
      fill_req  = 1'b1;
      fill_addr = faddr;
    end
    check("wb_ready", req_ready, 1);
    step();
    wb_req   = 1'b0;
    fill_req = 1'b0;
    wb_line  = ~line;
    wb_addr  = {$urandom, $urandom};
    check("wr_addr_cyc", bus_reqcyc, 1);
    check("wr_addr", bus_req, exp_a);
    check("wr_tag", bus_reqtag, MEM_WRITE);
    check("wr_busy", req_ready, 0);
    stable = 1'b1;
    repeat (ack_dly) begin
      step();
      if (!(bus_reqcyc && bus_req == exp_a && bus_reqtag == MEM_WRITE && !req_ready)) stable = 1'b0;
    end
    check("wr_addr_hold", stable, 1);
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    for (int i = 0; i < NB; i++) begin
      check("wr_beat", bus_req, line[i]);
      check("wr_beat_cyc", {bus_reqcyc, bus_reqtag}, {1'b1, MEM_WRITE});
      step();
    end
    check("wr_resp_cyc", bus_reqcyc, 0);
    bus_respcyc = 1'b1;
    bus_resptag = MEM_READ;
    step();
    bus_respcyc = 1'b0;
    check("wr_stray", {bus_respack, wb_done}, 0);
    repeat ($urandom_range(0, 3)) step();
    check("wr_wait_ready", req_ready, 0);
    bus_respcyc = 1'b1;
    bus_resptag = MEM_WRITE;
    step();
    bus_respcyc = 1'b0;
    check("wb_done", wb_done, 1);
    check("wr_respack", bus_respack, 1);
    n_wbs++;
`ifdef LTU_EVICT_FILL_EN
    chain = both;
`else
    chain = 1'b0;
`endif
    check("wb_done_ready", req_ready, !chain);
    if (chain) begin
      rd_phase(faddr & ~64'h3f, $urandom_range(0, 3), NB, 1'b0);
    end else begin
      step();
      check("wb_done_1cyc", {wb_done, bus_respack, bus_reqcyc}, 0);
    end
  endtask

  initial begin
    cache_line_t l;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {bus_reqcyc, bus_req, bus_reqtag, bus_respack, line_valid, wb_done}, 0);
    check("rst_line", line_data, 0);
    check("rst_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    step();

    fill_txn(64'h1234_5678, 2, NB, 1'b1);

    for (int i = 0; i < NB; i++) l[i] = 64'hA0 + 64'(i);
    wb_txn(64'h8000_0040, l, 1, 1'b0, 64'h0);

    for (int i = 0; i < NB; i++) l[i] = {$urandom, $urandom};
    wb_txn({$urandom, $urandom}, l, 0, 1'b1, {$urandom, $urandom});

    fill_txn({$urandom, $urandom}, 10, 4, 1'b0);

    // Abort a fill after five beats, then make sure a fresh fill is clean.
    fill_addr = {$urandom, $urandom};
    fill_req  = 1'b1;
    step();
    fill_req   = 1'b0;
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_respcyc = 1'b1;
      bus_resptag = MEM_READ;
      bus_resp    = {$urandom, $urandom};
      step();
      bus_respcyc = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    check("midrst_outs", {bus_reqcyc, bus_req, bus_reqtag, bus_respack, line_valid, wb_done}, 0);
    check("midrst_line", line_data, 0);
    check("midrst_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    fill_txn({$urandom, $urandom}, 1, NB, 1'b0);

    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 2))
        0: fill_txn({$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(0, NB), 1'b0);
        1: begin
          for (int i = 0; i < NB; i++) l[i] = {$urandom, $urandom};
          wb_txn({$urandom, $urandom}, l, $urandom_range(0, 4), 1'b0, 64'h0);
        end
        default: begin
          for (int i = 0; i < NB; i++) l[i] = {$urandom, $urandom};
          wb_txn({$urandom, $urandom}, l, $urandom_range(0, 4), 1'b1, {$urandom, $urandom});
        end
      endcase
    end

    repeat (2) step();
    check("valid_total", n_line_valid, n_fills);
    check("wb_done_total", n_wb_done, n_wbs);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
